// File: rtl/multibyte_add_sequencer.sv
// Multi-byte add/subtract sequencer: one 8-bit adder reused across NBYTES passes,
// least significant byte first, with a Start/ResultValid/ResultAck handshake.
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   Start, Sub          request and operation select (0 add, 1 subtract), sampled in IDLE
//   OpX, OpY            W-bit operands, latched on the accept edge
//   Busy                high whenever the sequencer is not idle
//   ResultValid         high while a finished result is offered
//   ResultAck           consumer accept, honoured only while ResultValid is high
//   Result              W-bit sum/difference modulo 2^W
//   CarryOut, Overflow  final carry (1 = no borrow for Sub) and signed overflow
module multibyte_add_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Sub,
    input  logic [8*NBYTES-1:0]   OpX,
    input  logic [8*NBYTES-1:0]   OpY,
    output logic                  Busy,
    output logic                  ResultValid,
    input  logic                  ResultAck,
    output logic [8*NBYTES-1:0]   Result,
    output logic                  CarryOut,
    output logic                  Overflow
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IDXW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;

    logic [W-1:0]     xReg;
    logic [W-1:0]     yReg;
    logic             subReg;
    logic             carryReg;
    logic [IDXW-1:0]  byteIdx;

    logic [7:0]       xByte;
    logic [7:0]       yByte;
    logic [7:0]       addSum;
    logic             addCarry;
    logic             isLast;

    assign isLast = (byteIdx == IDXW'(NBYTES - 1));

    // Shared byte adder; subtraction is X + ~Y + 1 with the +1 preloaded in carryReg.
    always_comb begin
        xByte              = xReg[{byteIdx, 3'b000} +: 8];
        yByte              = yReg[{byteIdx, 3'b000} +: 8] ^ {8{subReg}};
        {addCarry, addSum} = {1'b0, xByte} + {1'b0, yByte} + 9'(carryReg);
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (Start)     stateNext = ADD;
            ADD:     if (isLast)    stateNext = DONE;
            DONE:    if (ResultAck) stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            xReg        <= '0;
            yReg        <= '0;
            subReg      <= 1'b0;
            carryReg    <= 1'b0;
            byteIdx     <= '0;
            Result      <= '0;
            CarryOut    <= 1'b0;
            Overflow    <= 1'b0;
            Busy        <= 1'b0;
            ResultValid <= 1'b0;
        end else begin
            Busy        <= (stateNext != IDLE);
            ResultValid <= (stateNext == DONE);
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        xReg     <= OpX;
                        yReg     <= OpY;
                        subReg   <= Sub;
                        carryReg <= Sub;
                        byteIdx  <= '0;
                    end
                end
                ADD: begin
                    Result[{byteIdx, 3'b000} +: 8] <= addSum;
                    carryReg <= addCarry;
                    byteIdx  <= byteIdx + IDXW'(1);
                    // Top byte pass: its sign bits decide the signed overflow.
                    if (isLast) begin
                        CarryOut <= addCarry;
                        Overflow <= (xByte[7] == yByte[7]) && (addSum[7] != xByte[7]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
